// File: rtl/im_axil_rom.sv
// AXI4-Lite read-only instruction memory: one outstanding AR, fixed read latency,
// plus a synchronous load port for program preload.
module im_axil_rom #(
    parameter int unsigned ADDRLEN   = 32,
    parameter int unsigned DATALEN   = 32,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1,
    parameter string       INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_arvalid,
    output logic                     s_arready,
    input  logic [ADDRLEN-1:0]       s_araddr,
    output logic                     s_rvalid,
    input  logic                     s_rready,
    output logic [DATALEN-1:0]       s_rdata,
    output logic [1:0]               s_rresp,
    input  logic                     i_ld_en,
    input  logic [$clog2(DEPTH)-1:0] i_ld_addr,
    input  logic [DATALEN-1:0]       i_ld_data
);

    localparam int unsigned IDXW  = $clog2(DEPTH);
    localparam int unsigned CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'd4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    if (DATALEN != 32 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || LATENCY < 1) begin : g_bad_params
        $error("im_axil_rom: unsupported parameter set");
    end

    logic [DATALEN-1:0] mem [DEPTH];

    logic [1:0]         state_q,   state_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic               arready_q, arready_d;
    logic               rvalid_q,  rvalid_d;
    logic [DATALEN-1:0] rdata_q,   rdata_d;
    logic [1:0]         rresp_q,   rresp_d;

    logic               ar_err_c;
    logic [DATALEN-1:0] rd_word_c;

    // Load port is independent of reset and FSM state; NBA gives read-old-data on collision
    always_ff @(posedge clk) begin
        if (i_ld_en) mem[i_ld_addr] <= i_ld_data;
    end

    assign rd_word_c = mem[s_araddr[2 +: IDXW]];
    assign ar_err_c  = (s_araddr[1:0] != 2'b00) || (64'(s_araddr) >= LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        case (state_q)
            S_IDLE: begin
                arready_d = 1'b1;
                if (s_arvalid && arready_q) begin
                    arready_d = 1'b0;
                    rdata_d   = ar_err_c ? '0 : rd_word_c;
                    rresp_d   = ar_err_c ? RESP_SLVERR : RESP_OKAY;
                    if (LATENCY == 1) begin
                        state_d  = S_RESP;
                        rvalid_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d  = S_RESP;
                    rvalid_d = 1'b1;
                end
            end
            S_RESP: begin
                if (rvalid_q && s_rready) begin
                    state_d   = S_IDLE;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                arready_d = 1'b0;
                rvalid_d  = 1'b0;
            end
        endcase
    end

    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;

endmodule

// File: tb/tb_im_axil_rom.sv
// Scoreboard bench for im_axil_rom: three instances (latency 1, 3, 4) share clock,
// reset and load port; a negedge monitor checks every presented response.
module tb_im_axil_rom;

    logic        clk = 1'b0;
    logic        rst;
    logic        arv  [3];
    logic        arr  [3];
    logic [31:0] ara  [3];
    logic        rv   [3];
    logic        rrdy [3];
    logic [31:0] rd   [3];
    logic [1:0]  rr   [3];
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;

    typedef struct {
        int          d;
        logic [31:0] data;
        logic [1:0]  resp;
        int          hs;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem_m [1024];
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;
    logic        rv_prev [3];
    bit          stress_done;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    im_axil_rom #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .s_arvalid(arv[0]), .s_arready(arr[0]), .s_araddr(ara[0]),
        .s_rvalid(rv[0]), .s_rready(rrdy[0]), .s_rdata(rd[0]), .s_rresp(rr[0]),
        .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data));
    im_axil_rom #(.LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .s_arvalid(arv[1]), .s_arready(arr[1]), .s_araddr(ara[1]),
        .s_rvalid(rv[1]), .s_rready(rrdy[1]), .s_rdata(rd[1]), .s_rresp(rr[1]),
        .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data));
    im_axil_rom #(.LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .s_arvalid(arv[2]), .s_arready(arr[2]), .s_araddr(ara[2]),
        .s_rvalid(rv[2]), .s_rready(rrdy[2]), .s_rdata(rd[2]), .s_rresp(rr[2]),
        .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data));

    function automatic int lat(int d);
        return (d == 0) ? 1 : (d == 1) ? 3 : 4;
    endfunction

    task automatic chk(bit ok, string nm, int d, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s dut%0d: got %h, expected %h (cycle %0d)", nm, d, act, expv, cyc);
        end
    endtask

    // Expected response from the address rules alone
    function automatic exp_t expect_for(int d, logic [31:0] addr, int hs);
        exp_t e;
        e.d  = d;
        e.hs = hs;
        if (addr[1:0] != 2'b00 || addr >= 32'd4096) begin
            e.data = 32'h0;
            e.resp = 2'b10;
        end else begin
            e.data = mem_m[addr >> 2];
            e.resp = 2'b00;
        end
        return e;
    endfunction

    // Present AR from a negedge; the handshake edge is the next posedge once arready is seen
    task automatic issue(int d, logic [31:0] addr, bit ld = 1'b0, int li = 0, logic [31:0] ldat = 32'h0);
        int n = 0;
        bit done = 1'b0;
        @(negedge clk);
        arv[d] = 1'b1;
        ara[d] = addr;
        while (!done) begin
            if (arr[d] === 1'b1) begin
                q.push_back(expect_for(d, addr, cyc + 1));
                if (ld) begin
                    ld_en   = 1'b1;
                    ld_addr = 10'(li);
                    ld_data = ldat;
                end
                done = 1'b1;
            end else if (++n > 100) begin
                chk(1'b0, "ar_timeout", d, 32'(n), 32'd100);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        @(posedge clk);
        #1;
        arv[d] = 1'b0;
        ara[d] = $urandom;
        if (ld) mem_m[li] = ldat;
        ld_en = 1'b0;
    endtask

    task automatic load(int idx, logic [31:0] v);
        ld_en   = 1'b1;
        ld_addr = 10'(idx);
        ld_data = v;
        @(posedge clk);
        #1;
        mem_m[idx] = v;
        ld_en = 1'b0;
    endtask

    task automatic drain(int d);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) chk(1'b0, "drain_timeout", d, 32'(q.size()), 32'd0);
        @(negedge clk);
    endtask

    // Monitor: every presented response must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 3; d++) rv_prev[d] <= 1'b0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (rv[d] === 1'b1) begin
                    if (q.size() == 0 || q[0].d != d) begin
                        chk(1'b0, "unexpected_rvalid", d, 32'(rv[d]), 32'd0);
                    end else begin
                        chk(rd[d] === q[0].data, "rdata", d, rd[d], q[0].data);
                        chk(rr[d] === q[0].resp, "rresp", d, 32'(rr[d]), 32'(q[0].resp));
                        chk(arr[d] === 1'b0, "arready_with_rvalid", d, 32'(arr[d]), 32'd0);
                        if (!rv_prev[d])
                            chk(cyc == q[0].hs + lat(d) - 1, "rvalid_latency", d,
                                32'(cyc - q[0].hs + 1), 32'(lat(d)));
                        if (rrdy[d] === 1'b1) void'(q.pop_front());
                    end
                end
                rv_prev[d] <= rv[d];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        ld_en = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        stress_done = 1'b0;
        for (int d = 0; d < 3; d++) begin
            arv[d] = 1'b0; ara[d] = '0; rrdy[d] = 1'b1;
        end
        @(posedge clk);
        #1;
        // Preload while reset is held
        for (int i = 0; i < 200; i++) load(i, $urandom);
        load(0, 32'h0000_0013);
        load(1, 32'h0010_0093);
        load(4, 32'h0000_0000);

        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk(arr[d] === 1'b0, "reset_arready", d, 32'(arr[d]), 32'd0);
            chk(rv[d] === 1'b0, "reset_rvalid", d, 32'(rv[d]), 32'd0);
            chk(rd[d] === 32'h0, "reset_rdata", d, rd[d], 32'h0);
            chk(rr[d] === 2'b00, "reset_rresp", d, 32'(rr[d]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk(arr[0] === 1'b0, "arready_before_first_edge", 0, 32'(arr[0]), 32'd0);
        @(negedge clk);
        for (int d = 0; d < 3; d++)
            chk(arr[d] === 1'b1, "arready_after_release", d, 32'(arr[d]), 32'd1);

        // Latency 1 fetch pair, errors, in-range follow-up, load collision
        issue(0, 32'h0);
        issue(0, 32'h4);
        issue(0, 32'h2);
        issue(0, 32'h1000);
        issue(0, 32'hFFFF_FFFC);
        issue(0, 32'h8);
        issue(0, 32'h10, 1'b1, 4, 32'hDEAD_BEEF);
        issue(0, 32'h10);
        drain(0);

        // Backpressure on latency 3
        rrdy[1] = 1'b0;
        issue(1, 32'h4);
        begin
            int n = 0;
            while (rv[1] !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk(rv[1] === 1'b1, "bp_rvalid_seen", 1, 32'(rv[1]), 32'd1);
        end
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        rrdy[1] = 1'b1;
        drain(1);
        chk(arr[1] === 1'b1, "bp_arready_after_rready", 1, 32'(arr[1]), 32'd1);

        // Reset in the middle of a latency 4 transaction
        issue(2, 32'h4);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        repeat (3) begin
            @(negedge clk);
            chk(arr[2] === 1'b0, "midrst_arready", 2, 32'(arr[2]), 32'd0);
            chk(rv[2] === 1'b0, "midrst_rvalid", 2, 32'(rv[2]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk(arr[2] === 1'b1, "midrst_arready_after", 2, 32'(arr[2]), 32'd1);
        issue(2, 32'h0);
        drain(2);

        // Random arvalid gaps and rready on latency 3 over 200 sequential words
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    issue(1, 32'(i * 4));
                end
                stress_done = 1'b1;
            end
            begin
                while (!stress_done) begin
                    @(posedge clk);
                    #1;
                    rrdy[1] = 1'($urandom);
                end
            end
        join
        @(posedge clk);
        #1;
        rrdy[1] = 1'b1;
        drain(1);
        chk(q.size() == 0, "scoreboard_empty", 1, 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
